// File: rtl/reservation_station.sv
// Reservation station: holds issued ops until both operands arrive via CDB snoop,
// then dispatches the lowest-index ready entry to the ALU through registered outputs.
module reservation_station #(
   parameter int unsigned RS_SIZE  = 8,
   parameter int unsigned ROB_BITS = 4
) (
   input  logic                clk_in,
   input  logic                rstn_in,
   input  logic                rdy_in,
   input  logic                clear_in,
   input  logic                in_issue_enable,
   input  logic [5:0]          in_type,
   input  logic [31:0]         in_pc,
   input  logic [31:0]         in_imm,
   input  logic [ROB_BITS-1:0] in_reorder,
   input  logic                in_qj_valid,
   input  logic [ROB_BITS-1:0] in_qj,
   input  logic [31:0]         in_vj,
   input  logic                in_qk_valid,
   input  logic [ROB_BITS-1:0] in_qk,
   input  logic [31:0]         in_vk,
   output logic                out_full,
   input  logic                in_alu_cdb_enable,
   input  logic [ROB_BITS-1:0] in_alu_cdb_reorder,
   input  logic [31:0]         in_alu_cdb_result,
   input  logic                in_lsb_cdb_enable,
   input  logic [ROB_BITS-1:0] in_lsb_cdb_reorder,
   input  logic [31:0]         in_lsb_cdb_result,
   output logic                out_alu_enable,
   output logic [5:0]          out_alu_type,
   output logic [31:0]         out_alu_pc,
   output logic [31:0]         out_alu_imm,
   output logic [31:0]         out_alu_rs,
   output logic [31:0]         out_alu_rt,
   output logic [ROB_BITS-1:0] out_alu_reorder
);

   localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0]  busy_q, busy_d;
   logic [RS_SIZE-1:0]  qjv_q, qjv_d;
   logic [RS_SIZE-1:0]  qkv_q, qkv_d;
   logic [5:0]          type_q [RS_SIZE];
   logic [5:0]          type_d [RS_SIZE];
   logic [31:0]         pc_q   [RS_SIZE];
   logic [31:0]         pc_d   [RS_SIZE];
   logic [31:0]         imm_q  [RS_SIZE];
   logic [31:0]         imm_d  [RS_SIZE];
   logic [ROB_BITS-1:0] rob_q  [RS_SIZE];
   logic [ROB_BITS-1:0] rob_d  [RS_SIZE];
   logic [ROB_BITS-1:0] qj_q   [RS_SIZE];
   logic [ROB_BITS-1:0] qj_d   [RS_SIZE];
   logic [ROB_BITS-1:0] qk_q   [RS_SIZE];
   logic [ROB_BITS-1:0] qk_d   [RS_SIZE];
   logic [31:0]         vj_q   [RS_SIZE];
   logic [31:0]         vj_d   [RS_SIZE];
   logic [31:0]         vk_q   [RS_SIZE];
   logic [31:0]         vk_d   [RS_SIZE];

   logic                alu_en_q, alu_en_d;
   logic [5:0]          alu_type_q, alu_type_d;
   logic [31:0]         alu_pc_q, alu_pc_d;
   logic [31:0]         alu_imm_q, alu_imm_d;
   logic [31:0]         alu_rs_q, alu_rs_d;
   logic [31:0]         alu_rt_q, alu_rt_d;
   logic [ROB_BITS-1:0] alu_rob_q, alu_rob_d;

   logic [RS_SIZE-1:0]  ready;
   logic                full;
   logic                disp_found;
   logic [IdxW-1:0]     disp_idx;
   logic [IdxW-1:0]     free_idx;
   logic [32:0]         opj, opk;

   // Returns {still_pending, value}; the ALU CDB wins when both buses carry the tag.
   function automatic logic [32:0] fwd(input logic pend, input logic [ROB_BITS-1:0] tag,
                                       input logic [31:0] val);
      logic [32:0] res;
      res = {pend, val};
      if (pend && in_alu_cdb_enable && in_alu_cdb_reorder == tag) begin
         res = {1'b0, in_alu_cdb_result};
      end else if (pend && in_lsb_cdb_enable && in_lsb_cdb_reorder == tag) begin
         res = {1'b0, in_lsb_cdb_result};
      end
      return res;
   endfunction

   assign ready    = busy_q & ~qjv_q & ~qkv_q;
   assign full     = &busy_q;
   assign out_full = full;

   always_comb begin
      disp_found = 1'b0;
      disp_idx   = '0;
      free_idx   = '0;
      for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
         if (ready[i]) begin
            disp_found = 1'b1;
            disp_idx   = IdxW'(i);
         end
         if (!busy_q[i]) free_idx = IdxW'(i);
      end
   end

   always_comb begin
      busy_d = busy_q;
      qjv_d  = qjv_q;
      qkv_d  = qkv_q;
      type_d = type_q;
      pc_d   = pc_q;
      imm_d  = imm_q;
      rob_d  = rob_q;
      qj_d   = qj_q;
      qk_d   = qk_q;
      vj_d   = vj_q;
      vk_d   = vk_q;
      opj    = '0;
      opk    = '0;
      if (clear_in) begin
         busy_d = '0;
      end else if (rdy_in) begin
         for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (busy_q[i]) begin
               {qjv_d[i], vj_d[i]} = fwd(qjv_q[i], qj_q[i], vj_q[i]);
               {qkv_d[i], vk_d[i]} = fwd(qkv_q[i], qk_q[i], vk_q[i]);
            end
         end
         if (disp_found) busy_d[disp_idx] = 1'b0;
         // The free slot is non-busy pre-edge, so it never collides with the dispatch slot.
         if (in_issue_enable && !full) begin
            opj                = fwd(in_qj_valid, in_qj, in_vj);
            opk                = fwd(in_qk_valid, in_qk, in_vk);
            busy_d[free_idx]   = 1'b1;
            type_d[free_idx]   = in_type;
            pc_d[free_idx]     = in_pc;
            imm_d[free_idx]    = in_imm;
            rob_d[free_idx]    = in_reorder;
            qj_d[free_idx]     = in_qj;
            qk_d[free_idx]     = in_qk;
            {qjv_d[free_idx], vj_d[free_idx]} = opj;
            {qkv_d[free_idx], vk_d[free_idx]} = opk;
         end
      end
   end

   always_comb begin
      alu_en_d   = 1'b0;
      alu_type_d = alu_type_q;
      alu_pc_d   = alu_pc_q;
      alu_imm_d  = alu_imm_q;
      alu_rs_d   = alu_rs_q;
      alu_rt_d   = alu_rt_q;
      alu_rob_d  = alu_rob_q;
      if (!clear_in && rdy_in && disp_found) begin
         alu_en_d   = 1'b1;
         alu_type_d = type_q[disp_idx];
         alu_pc_d   = pc_q[disp_idx];
         alu_imm_d  = imm_q[disp_idx];
         alu_rs_d   = vj_q[disp_idx];
         alu_rt_d   = vk_q[disp_idx];
         alu_rob_d  = rob_q[disp_idx];
      end
   end

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         busy_q     <= '0;
         qjv_q      <= '0;
         qkv_q      <= '0;
         for (int i = 0; i < int'(RS_SIZE); i++) begin
            type_q[i] <= '0;
            pc_q[i]   <= '0;
            imm_q[i]  <= '0;
            rob_q[i]  <= '0;
            qj_q[i]   <= '0;
            qk_q[i]   <= '0;
            vj_q[i]   <= '0;
            vk_q[i]   <= '0;
         end
         alu_en_q   <= 1'b0;
         alu_type_q <= '0;
         alu_pc_q   <= '0;
         alu_imm_q  <= '0;
         alu_rs_q   <= '0;
         alu_rt_q   <= '0;
         alu_rob_q  <= '0;
      end else begin
         busy_q     <= busy_d;
         qjv_q      <= qjv_d;
         qkv_q      <= qkv_d;
         type_q     <= type_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         rob_q      <= rob_d;
         qj_q       <= qj_d;
         qk_q       <= qk_d;
         vj_q       <= vj_d;
         vk_q       <= vk_d;
         alu_en_q   <= alu_en_d;
         alu_type_q <= alu_type_d;
         alu_pc_q   <= alu_pc_d;
         alu_imm_q  <= alu_imm_d;
         alu_rs_q   <= alu_rs_d;
         alu_rt_q   <= alu_rt_d;
         alu_rob_q  <= alu_rob_d;
      end
   end

   assign out_alu_enable  = alu_en_q;
   assign out_alu_type    = alu_type_q;
   assign out_alu_pc      = alu_pc_q;
   assign out_alu_imm     = alu_imm_q;
   assign out_alu_rs      = alu_rs_q;
   assign out_alu_rt      = alu_rt_q;
   assign out_alu_reorder = alu_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus randomized
// traffic compared against an entry-list reference model.
module tb_reservation_station;

   localparam int N = 8;
   localparam logic [5:0] TypeAdd = 6'h01;

   logic        clk_in = 1'b0;
   logic        rstn_in, rdy_in, clear_in, in_issue_enable;
   logic [5:0]  in_type;
   logic [31:0] in_pc, in_imm, in_vj, in_vk;
   logic [3:0]  in_reorder, in_qj, in_qk;
   logic        in_qj_valid, in_qk_valid;
   logic        out_full;
   logic        in_alu_cdb_enable, in_lsb_cdb_enable;
   logic [3:0]  in_alu_cdb_reorder, in_lsb_cdb_reorder;
   logic [31:0] in_alu_cdb_result, in_lsb_cdb_result;
   logic        out_alu_enable;
   logic [5:0]  out_alu_type;
   logic [31:0] out_alu_pc, out_alu_imm, out_alu_rs, out_alu_rt;
   logic [3:0]  out_alu_reorder;

   int checks = 0;
   int errors = 0;

   reservation_station #(.RS_SIZE(N), .ROB_BITS(4)) dut (
      .clk_in(clk_in), .rstn_in(rstn_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .in_issue_enable(in_issue_enable), .in_type(in_type), .in_pc(in_pc), .in_imm(in_imm),
      .in_reorder(in_reorder), .in_qj_valid(in_qj_valid), .in_qj(in_qj), .in_vj(in_vj),
      .in_qk_valid(in_qk_valid), .in_qk(in_qk), .in_vk(in_vk), .out_full(out_full),
      .in_alu_cdb_enable(in_alu_cdb_enable), .in_alu_cdb_reorder(in_alu_cdb_reorder),
      .in_alu_cdb_result(in_alu_cdb_result), .in_lsb_cdb_enable(in_lsb_cdb_enable),
      .in_lsb_cdb_reorder(in_lsb_cdb_reorder), .in_lsb_cdb_result(in_lsb_cdb_result),
      .out_alu_enable(out_alu_enable), .out_alu_type(out_alu_type), .out_alu_pc(out_alu_pc),
      .out_alu_imm(out_alu_imm), .out_alu_rs(out_alu_rs), .out_alu_rt(out_alu_rt),
      .out_alu_reorder(out_alu_reorder)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      bit        busy;
      bit [5:0]  typ;
      bit [31:0] pc;
      bit [31:0] imm;
      bit [3:0]  rob;
      bit        qjv;
      bit [3:0]  qj;
      bit [31:0] vj;
      bit        qkv;
      bit [3:0]  qk;
      bit [31:0] vk;
   } ent_t;

   ent_t      m [N];
   bit        m_en;
   bit [5:0]  m_type;
   bit [31:0] m_pc, m_imm, m_rs, m_rt;
   bit [3:0]  m_rob;

   function automatic bit [32:0] resolve(bit pend, bit [3:0] tag, bit [31:0] val);
      if (!pend) return {1'b0, val};
      if (in_alu_cdb_enable && in_alu_cdb_reorder == tag) return {1'b0, in_alu_cdb_result};
      if (in_lsb_cdb_enable && in_lsb_cdb_reorder == tag) return {1'b0, in_lsb_cdb_result};
      return {1'b1, val};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m[i] = '0;
      m_en = 0; m_type = 0; m_pc = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rob = 0;
   endfunction

   // Advances the model across one clock edge using the inputs currently applied.
   function automatic void model_step();
      int d = -1;
      int f = -1;
      bit [32:0] r;
      if (clear_in) begin
         for (int i = 0; i < N; i++) m[i].busy = 0;
         m_en = 0;
         return;
      end
      if (!rdy_in) begin
         m_en = 0;
         return;
      end
      for (int i = 0; i < N; i++) begin
         if (d < 0 && m[i].busy && !m[i].qjv && !m[i].qkv) d = i;
         if (f < 0 && !m[i].busy) f = i;
      end
      m_en = (d >= 0);
      if (d >= 0) begin
         m_type = m[d].typ; m_pc = m[d].pc; m_imm = m[d].imm;
         m_rs = m[d].vj; m_rt = m[d].vk; m_rob = m[d].rob;
         m[d].busy = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (m[i].busy) begin
            r = resolve(m[i].qjv, m[i].qj, m[i].vj); m[i].qjv = r[32]; m[i].vj = r[31:0];
            r = resolve(m[i].qkv, m[i].qk, m[i].vk); m[i].qkv = r[32]; m[i].vk = r[31:0];
         end
      end
      if (in_issue_enable && f >= 0) begin
         m[f].busy = 1; m[f].typ = in_type; m[f].pc = in_pc; m[f].imm = in_imm;
         m[f].rob = in_reorder; m[f].qj = in_qj; m[f].qk = in_qk;
         r = resolve(in_qj_valid, in_qj, in_vj); m[f].qjv = r[32]; m[f].vj = r[31:0];
         r = resolve(in_qk_valid, in_qk, in_vk); m[f].qkv = r[32]; m[f].vk = r[31:0];
      end
   endfunction

   task automatic idle();
      rdy_in = 1; clear_in = 0; in_issue_enable = 0; in_type = 0; in_pc = 0; in_imm = 0;
      in_reorder = 0; in_qj_valid = 0; in_qj = 0; in_vj = 0; in_qk_valid = 0; in_qk = 0;
      in_vk = 0; in_alu_cdb_enable = 0; in_alu_cdb_reorder = 0; in_alu_cdb_result = 0;
      in_lsb_cdb_enable = 0; in_lsb_cdb_reorder = 0; in_lsb_cdb_result = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rstn_in = 0;
      model_reset();
      @(posedge clk_in);
      #1;
      rstn_in = 1;
   endtask

   task automatic set_issue(input bit [3:0] rob, input bit qjv, input bit [3:0] qj,
                            input bit [31:0] vj, input bit qkv, input bit [3:0] qk,
                            input bit [31:0] vk);
      in_issue_enable = 1; in_type = TypeAdd; in_pc = {24'h0, 4'h0, rob} << 2;
      in_imm = 32'h100 + 32'(rob); in_reorder = rob; in_qj_valid = qjv; in_qj = qj;
      in_vj = vj; in_qk_valid = qkv; in_qk = qk; in_vk = vk;
   endtask

   task automatic test_reset();
      rstn_in = 1; idle();
      #2 rstn_in = 0;
      #1;
      checks++; if (out_alu_enable !== 1'b0) begin errors++;
         $display("FAIL reset_en got %0h want 0", out_alu_enable); end
      checks++; if (out_full !== 1'b0) begin errors++;
         $display("FAIL reset_full got %0h want 0", out_full); end
      checks++; if ({out_alu_rs, out_alu_rt, out_alu_reorder} !== 68'h0) begin errors++;
         $display("FAIL reset_fields got %0h %0h %0h want 0", out_alu_rs, out_alu_rt,
                  out_alu_reorder); end
      model_reset();
      @(posedge clk_in); #1; rstn_in = 1;
      tick();
      checks++; if (out_alu_enable !== 1'b0) begin errors++;
         $display("FAIL idle_en got %0h want 0", out_alu_enable); end
   endtask

   task automatic test_both_ready();
      do_reset();
      set_issue(4'd3, 0, 0, 32'd5, 0, 0, 32'd7);
      tick(); idle();
      checks++; if (out_alu_enable !== 1'b0) begin errors++;
         $display("FAIL ready_no_bypass got %0h want 0", out_alu_enable); end
      tick();
      checks++; if (out_alu_enable !== 1'b1) begin errors++;
         $display("FAIL ready_en got %0h want 1", out_alu_enable); end
      checks++; if ({out_alu_rs, out_alu_rt, out_alu_reorder} !== {32'd5, 32'd7, 4'd3}) begin
         errors++; $display("FAIL ready_fields got rs=%0h rt=%0h rob=%0h want 5 7 3",
                            out_alu_rs, out_alu_rt, out_alu_reorder); end
      checks++; if (out_alu_type !== TypeAdd) begin errors++;
         $display("FAIL ready_type got %0h want %0h", out_alu_type, TypeAdd); end
      tick();
      checks++; if (out_alu_enable !== 1'b0) begin errors++;
         $display("FAIL ready_once got %0h want 0", out_alu_enable); end
      checks++; if (out_alu_rs !== 32'd5) begin errors++;
         $display("FAIL ready_hold got %0h want 5", out_alu_rs); end
   endtask

   task automatic test_wakeup();
      do_reset();
      set_issue(4'd4, 1, 4'd2, 32'd0, 0, 0, 32'd1);
      tick(); idle(); tick();
      checks++; if (out_alu_enable !== 1'b0) begin errors++;
         $display("FAIL wake_wait got %0h want 0", out_alu_enable); end
      in_alu_cdb_enable = 1; in_alu_cdb_reorder = 4'd2; in_alu_cdb_result = 32'h10;
      tick(); idle();
      checks++; if (out_alu_enable !== 1'b0) begin errors++;
         $display("FAIL wake_no_bypass got %0h want 0", out_alu_enable); end
      tick();
      checks++; if ({out_alu_enable, out_alu_rs, out_alu_rt} !== {1'b1, 32'h10, 32'd1}) begin
         errors++; $display("FAIL wake_dispatch got en=%0h rs=%0h rt=%0h want 1 10 1",
                            out_alu_enable, out_alu_rs, out_alu_rt); end
   endtask

   task automatic test_forward();
      do_reset();
      set_issue(4'd1, 1, 4'd5, 32'd0, 0, 0, 32'd2);
      in_lsb_cdb_enable = 1; in_lsb_cdb_reorder = 4'd5; in_lsb_cdb_result = 32'hAB;
      tick(); idle(); tick();
      checks++; if ({out_alu_enable, out_alu_rs} !== {1'b1, 32'hAB}) begin errors++;
         $display("FAIL fwd_lsb got en=%0h rs=%0h want 1 ab", out_alu_enable, out_alu_rs); end
      // Both buses carry the same tag: ALU result must be taken.
      set_issue(4'd2, 0, 0, 32'd9, 1, 4'd6, 32'd0);
      in_alu_cdb_enable = 1; in_alu_cdb_reorder = 4'd6; in_alu_cdb_result = 32'h11;
      in_lsb_cdb_enable = 1; in_lsb_cdb_reorder = 4'd6; in_lsb_cdb_result = 32'h22;
      tick(); idle(); tick();
      checks++; if ({out_alu_enable, out_alu_rt} !== {1'b1, 32'h11}) begin errors++;
         $display("FAIL fwd_alu_wins got en=%0h rt=%0h want 1 11", out_alu_enable,
                  out_alu_rt); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < N; i++) begin
         set_issue(4'(i), 1, (i == 0) ? 4'd1 : 4'd9, 32'd0, 0, 0, 32'd3);
         tick();
      end
      checks++; if (out_full !== 1'b1) begin errors++;
         $display("FAIL full_set got %0h want 1", out_full); end
      set_issue(4'd15, 0, 0, 32'd1, 0, 0, 32'd1);
      tick(); idle();
      checks++; if ({out_full, out_alu_enable} !== 2'b10) begin errors++;
         $display("FAIL full_ignore got full=%0h en=%0h want 1 0", out_full, out_alu_enable); end
      in_alu_cdb_enable = 1; in_alu_cdb_reorder = 4'd1; in_alu_cdb_result = 32'h55;
      tick(); idle(); tick();
      checks++; if ({out_alu_enable, out_alu_reorder, out_alu_rs} !== {1'b1, 4'd0, 32'h55})
         begin errors++; $display("FAIL full_wake0 got en=%0h rob=%0h rs=%0h want 1 0 55",
                                  out_alu_enable, out_alu_reorder, out_alu_rs); end
      checks++; if (out_full !== 1'b0) begin errors++;
         $display("FAIL full_freed got %0h want 0", out_full); end
      set_issue(4'd12, 0, 0, 32'd4, 0, 0, 32'd4);
      tick(); idle();
      checks++; if (out_full !== 1'b1) begin errors++;
         $display("FAIL full_refill got %0h want 1", out_full); end
      tick();
      checks++; if ({out_alu_enable, out_alu_reorder} !== {1'b1, 4'd12}) begin errors++;
         $display("FAIL full_new got en=%0h rob=%0h want 1 c", out_alu_enable,
                  out_alu_reorder); end
      in_alu_cdb_enable = 1; in_alu_cdb_reorder = 4'd9; in_alu_cdb_result = 32'h99;
      tick(); idle();
      for (int i = 1; i < N; i++) begin
         tick();
         checks++; if ({out_alu_enable, out_alu_reorder} !== {1'b1, 4'(i)}) begin errors++;
            $display("FAIL full_drain%0d got en=%0h rob=%0h want 1 %0h", i, out_alu_enable,
                     out_alu_reorder, i); end
      end
      tick();
      checks++; if (out_alu_enable !== 1'b0) begin errors++;
         $display("FAIL full_drained got %0h want 0", out_alu_enable); end
   endtask

   task automatic test_flush();
      do_reset();
      set_issue(4'd0, 1, 4'd3, 32'd0, 0, 0, 32'd0); tick();
      set_issue(4'd1, 1, 4'd3, 32'd0, 0, 0, 32'd0); tick();
      set_issue(4'd2, 0, 0, 32'd1, 0, 0, 32'd1); tick();
      set_issue(4'd9, 0, 0, 32'd2, 0, 0, 32'd2);
      clear_in = 1;
      tick(); idle();
      checks++; if ({out_alu_enable, out_full} !== 2'b00) begin errors++;
         $display("FAIL flush_now got en=%0h full=%0h want 0 0", out_alu_enable, out_full); end
      in_alu_cdb_enable = 1; in_alu_cdb_reorder = 4'd3; in_alu_cdb_result = 32'h7;
      tick(); idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (out_alu_enable !== 1'b0) begin errors++;
            $display("FAIL flush_after%0d got %0h want 0", i, out_alu_enable); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_issue(4'd3, 0, 0, 32'd5, 0, 0, 32'd7); tick();
      set_issue(4'd4, 1, 4'd8, 32'd0, 0, 0, 32'd0); tick(); idle();
      checks++; if (out_alu_enable !== 1'b1) begin errors++;
         $display("FAIL arst_pre got %0h want 1", out_alu_enable); end
      #2 rstn_in = 0;
      #1;
      checks++; if ({out_alu_enable, out_alu_rs, out_alu_rt, out_alu_reorder, out_full} !== '0)
         begin errors++; $display("FAIL arst_now got en=%0h rs=%0h rt=%0h rob=%0h full=%0h",
                                  out_alu_enable, out_alu_rs, out_alu_rt, out_alu_reorder,
                                  out_full); end
      model_reset();
      @(posedge clk_in); #1; rstn_in = 1;
      in_alu_cdb_enable = 1; in_alu_cdb_reorder = 4'd8; in_alu_cdb_result = 32'h1;
      set_issue(4'd3, 0, 0, 32'd5, 0, 0, 32'd7);
      tick(); idle(); tick();
      checks++; if ({out_alu_enable, out_alu_rs, out_alu_rt, out_alu_reorder} !==
                    {1'b1, 32'd5, 32'd7, 4'd3}) begin errors++;
         $display("FAIL arst_after got en=%0h rs=%0h rt=%0h rob=%0h", out_alu_enable,
                  out_alu_rs, out_alu_rt, out_alu_reorder); end
      tick();
      checks++; if (out_alu_enable !== 1'b0) begin errors++;
         $display("FAIL arst_discard got %0h want 0", out_alu_enable); end
   endtask

   task automatic test_random();
      bit exp_full;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rdy_in             = ($urandom_range(0, 9) != 0);
         clear_in           = ($urandom_range(0, 59) == 0);
         in_issue_enable    = ($urandom_range(0, 2) != 0);
         in_type            = 6'($urandom);
         in_pc              = $urandom;
         in_imm             = $urandom;
         in_reorder         = 4'($urandom);
         in_qj_valid        = $urandom_range(0, 1) == 1;
         in_qj              = 4'($urandom_range(0, 3));
         in_vj              = $urandom;
         in_qk_valid        = $urandom_range(0, 1) == 1;
         in_qk              = 4'($urandom_range(0, 3));
         in_vk              = $urandom;
         in_alu_cdb_enable  = $urandom_range(0, 1) == 1;
         in_alu_cdb_reorder = 4'($urandom_range(0, 3));
         in_alu_cdb_result  = $urandom;
         in_lsb_cdb_enable  = $urandom_range(0, 1) == 1;
         in_lsb_cdb_reorder = 4'($urandom_range(0, 3));
         in_lsb_cdb_result  = $urandom;
         tick();
         exp_full = 1;
         for (int i = 0; i < N; i++) exp_full &= m[i].busy;
         checks++;
         if ({out_alu_enable, out_full, out_alu_type, out_alu_pc, out_alu_imm, out_alu_rs,
              out_alu_rt, out_alu_reorder} !==
             {m_en, exp_full, m_type, m_pc, m_imm, m_rs, m_rt, m_rob}) begin
            errors++;
            $display("FAIL rand_c%0d got en=%0h full=%0h rob=%0h rs=%0h rt=%0h want en=%0h full=%0h rob=%0h rs=%0h rt=%0h",
                     c, out_alu_enable, out_full, out_alu_reorder, out_alu_rs, out_alu_rt,
                     m_en, exp_full, m_rob, m_rs, m_rt);
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_both_ready();
      test_wakeup();
      test_forward();
      test_full();
      test_flush();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of entries.
REQ-002 SHALL have parameter ROB_BITS, default 4, ROB tag width.
REQ-003 SHALL have port clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global ready; low = pause.
REQ-006 SHALL have port clear_in  input  1  synchronous flush on branch mispredict.
REQ-007 SHALL have issue ports, all inputs:
- in_issue_enable (1)
- in_type (6)
- in_pc (32)
- in_imm (32)
- in_reorder (ROB_BITS)
- in_qj_valid (1), in_qj (ROB_BITS), in_vj (32): operand j
- in_qk_valid (1), in_qk (ROB_BITS), in_vk (32): operand k
- q*_valid=1 means the operand is still pending on that ROB tag.
REQ-008 SHALL have port out_full  output  1  no free entry.
REQ-009 SHALL have ALU result snoop inputs: in_alu_cdb_enable (1), in_alu_cdb_reorder (ROB_BITS), in_alu_cdb_result (32).
REQ-010 SHALL have LSB result snoop inputs: in_lsb_cdb_enable (1), in_lsb_cdb_reorder (ROB_BITS), in_lsb_cdb_result (32).
REQ-011 SHALL have registered ALU dispatch outputs: out_alu_enable (1), out_alu_type (6), out_alu_pc (32), out_alu_imm (32), out_alu_rs (32), out_alu_rt (32), out_alu_reorder (ROB_BITS).

Function
REQ-012 SHALL hold RS_SIZE entries, each with: busy, type, pc, imm, reorder, qj_valid/qj/vj, qk_valid/qk/vk.
REQ-013 Issue: when in_issue_enable=1 and out_full=0, the request SHALL be written at the clock edge into the lowest-index non-busy entry, and that entry's busy bit set.
REQ-014 An issue while out_full=1 SHALL be ignored, with no state change.
REQ-015 out_full SHALL equal 1 exactly when all entries are busy in registered state; an entry freed by dispatch at edge N is issuable from cycle N+1.
REQ-016 Issue-time forwarding: if in_qj_valid=1 and a CDB with enable=1 carries reorder==in_qj in the same cycle, the entry SHALL store qj_valid=0 and vj=that result; the same rule applies to k.
REQ-017 Snoop: for every busy entry with qj_valid=1 and qj matching an enabled CDB tag, the edge SHALL clear qj_valid and load vj from that CDB's result; the same rule applies to k.
REQ-018 If both CDBs match the same tag, the ALU CDB SHALL win.
REQ-019 An entry SHALL be ready when busy=1, qj_valid=0 and qk_valid=0, all in registered state.
REQ-020 Dispatch: each edge, the lowest-index ready entry SHALL be copied to the out_alu_* registers (vj to out_alu_rs, vk to out_alu_rt), out_alu_enable set to 1, and its busy bit cleared.
REQ-021 If no entry is ready, out_alu_enable SHALL be 0 and the other out_alu_* outputs SHALL hold their previous values.
REQ-022 Latency: an entry issued or woken at edge N SHALL be dispatched no earlier than edge N+1; there is no same-cycle bypass into dispatch.
REQ-023 out_alu_enable SHALL be high for exactly one cycle per dispatched entry, and each entry SHALL be dispatched exactly once.
REQ-024 clear_in=1 at an edge SHALL clear all busy bits and out_alu_enable, and SHALL drop any same-cycle issue and dispatch; clear_in has priority over rdy_in.
REQ-025 rdy_in=0 (with clear_in=0) SHALL freeze all entry state, ignore issue and snoop, and drive out_alu_enable to 0 at that edge.
REQ-026 Simultaneous issue and dispatch in one cycle SHALL both take effect; the issue slot choice SHALL use pre-edge busy bits.

Reset
REQ-027 rstn_in=0 SHALL immediately, without waiting for a clock edge:
- clear all busy bits
- drive out_alu_enable=0 and all other out_alu_* outputs to 0
- drive out_full=0
REQ-028 Assertion of rstn_in mid-operation SHALL discard all pending entries, with normal operation from the first edge after release.

Verification
REQ-029 Both operands ready: issue type=ADD, vj=5, vk=7, reorder=3 at edge 1 -> cycle after edge 2: out_alu_enable=1, rs=5, rt=7, reorder=3; cycle after edge 3: enable=0.
REQ-030 Wakeup via ALU CDB: issue qj_valid=1, qj=2, vk=1 -> no dispatch; ALU CDB tag 2, result 0x10 at edge N -> dispatch at edge N+1 with rs=0x10, rt=1.
REQ-031 Issue-time forwarding: issue qj=5 while LSB CDB broadcasts tag 5, result 0xAB -> dispatch at the next edge with rs=0xAB.
REQ-032 Full boundary:
- 8 issues, each with pending tags -> out_full=1, and a 9th issue is ignored.
- Wake entry 0 -> it dispatches, and out_full=0 the following cycle.
- New issue -> lands in entry 0.
REQ-033 Flush: 3 busy entries plus clear_in=1 with simultaneous issue -> next cycle all empty, out_alu_enable=0, out_full=0, no later dispatch.
REQ-034 Async reset: rstn_in low mid-cycle while out_alu_enable=1 -> outputs 0 before the next edge; after release, REQ-029 passes.
